// File: rtl/hdmi_packet_engine.sv
// HDMI data-island packet engine: packet FIFO, per-line island scheduler and BCH/TERC4 nibble streamer.
// Optional macro HDMI_PKT_NULL_FILL_EN: send one Null packet on lines whose FIFO is empty.
module hdmi_packet_engine #(
  parameter int DEPTH         = 8,
  parameter int MAX_PKTS      = 2,
  parameter int ISLAND_OFFSET = 4,
  parameter int PREAMBLE_LEN  = 8
) (
  input  logic                     i_pixclk,
  input  logic                     i_rst_n,
  input  logic                     i_hSync,
  input  logic                     i_vSync,
  input  logic                     i_blank,
  input  logic                     i_pkt_valid,
  output logic                     o_pkt_ready,
  input  logic [23:0]              i_pkt_hdr,
  input  logic [223:0]             i_pkt_sub,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [3:0]               o_d0,
  output logic [3:0]               o_d1,
  output logic [3:0]               o_d2,
  output logic                     o_data,
  output logic                     o_preamble,
  output logic                     o_guard,
  output logic                     o_overrun,
  output logic [2:0]               o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] OFF_LAST = (ISLAND_OFFSET >= 2) ? 8'(ISLAND_OFFSET - 2) : 8'd0;
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OFFSET, S_PREAMBLE, S_LGUARD, S_PACKET, S_TGUARD
  } state_t;

  // Handshake: a packet transfers on any rising edge where i_pkt_valid && o_pkt_ready;
  // o_pkt_ready is registered and means "level < DEPTH" for the current cycle.
  logic [23:0]   hdr_mem [DEPTH];
  logic [223:0]  sub_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_next;
  logic          wr_en, rd_en;

  assign wr_en        = i_pkt_valid && o_pkt_ready;
  assign o_fifo_level = level;

  always_comb begin
    level_next = level;
    case ({wr_en, rd_en})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      o_pkt_ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level       <= level_next;
      o_pkt_ready <= (level_next < LW'(DEPTH));
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (wr_en) begin
      hdr_mem[wr_ptr] <= i_pkt_hdr;
      sub_mem[wr_ptr] <= i_pkt_sub;
    end
  end

  // Island scheduler
  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [4:0]  c;
  logic [4:0]  pkt_idx, n_pkts, n_sel;
  logic        stop, null_pkt, null_sel, blank_q;
  logic        rise, decide, go, load, abort, last_pkt;

  assign c           = cnt[4:0];
  assign rise        = i_blank && !blank_q;
  assign abort       = (state inside {S_PREAMBLE, S_LGUARD, S_PACKET}) && !i_blank;
  assign last_pkt    = stop || abort || (pkt_idx + 5'd1 == n_pkts);
  assign decide      = ((state == S_IDLE) && rise && (ISLAND_OFFSET == 1)) ||
                       ((state == S_OFFSET) && (cnt == OFF_LAST));
  assign rd_en       = load && !null_pkt;
  assign o_dbg_state = state;

`ifdef HDMI_PKT_NULL_FILL_EN
  assign go = decide;
`else
  assign go = decide && (level != '0);
`endif

  always_comb begin
    null_sel = 1'b0;
    if (level == '0) begin
      n_sel    = 5'd1;
      null_sel = 1'b1;
    end else if (32'(level) > MAX_PKTS) begin
      n_sel = 5'(MAX_PKTS);
    end else begin
      n_sel = 5'(level);
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      S_IDLE:     if (rise) state_n = (ISLAND_OFFSET == 1) ? (go ? S_PREAMBLE : S_IDLE) : S_OFFSET;
      S_OFFSET:   if (decide) state_n = go ? S_PREAMBLE : S_IDLE;
      S_PREAMBLE: if (cnt == PRE_LAST) state_n = S_LGUARD;
      S_LGUARD:   if (cnt == 8'd1) begin
                    state_n = S_PACKET;
                    load    = 1'b1;
                  end
      S_PACKET:   if (c == 5'd31) begin
                    if (last_pkt) state_n = S_TGUARD;
                    else          load    = 1'b1;
                  end
      S_TGUARD:   if (cnt == 8'd1) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pkt_idx   <= '0;
      n_pkts    <= '0;
      stop      <= 1'b0;
      null_pkt  <= 1'b0;
      blank_q   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state   <= state_n;
      blank_q <= i_blank;
      cnt     <= ((state_n != state) || load) ? 8'd0 : cnt + 8'd1;
      if (go) begin
        n_pkts   <= n_sel;
        null_pkt <= null_sel;
        pkt_idx  <= '0;
        stop     <= 1'b0;
      end else begin
        if (abort) stop <= 1'b1;
        if ((state == S_PACKET) && (c == 5'd31)) pkt_idx <= pkt_idx + 5'd1;
      end
      if (abort) o_overrun <= 1'b1;
    end
  end

  // Packet holding registers and BCH datapath
  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    bch_step = {1'b0, e[7:1]} ^ ((e[0] ^ b) ? 8'hC1 : 8'h00);
  endfunction

  logic [23:0]      hdr_cur;
  logic [223:0]     sub_cur;
  logic [7:0]       hecc, hecc_n, e1;
  logic [3:0][7:0]  secc, secc_n;
  logic [31:0]      hdr_w;
  logic [63:0]      sub_w;
  logic             hbit;
  logic [3:0]       d0_n, d1_n, d2_n;

  always_comb begin
    hdr_w  = {8'h00, hdr_cur};
    hecc_n = bch_step((c == 5'd0) ? 8'h00 : hecc, hdr_w[c]);
    hbit   = (c < 5'd24) ? hdr_w[c] : hecc[c[2:0]];
    secc_n = secc;
    sub_w  = '0;
    e1     = '0;
    d1_n   = '0;
    d2_n   = '0;
    for (int k = 0; k < 4; k++) begin
      sub_w     = {8'h00, sub_cur[56*k +: 56]};
      e1        = bch_step((c == 5'd0) ? 8'h00 : secc[k], sub_w[{c, 1'b0}]);
      secc_n[k] = bch_step(e1, sub_w[{c, 1'b1}]);
      if (c < 5'd28) begin
        d1_n[k] = sub_w[{c, 1'b0}];
        d2_n[k] = sub_w[{c, 1'b1}];
      end else begin
        d1_n[k] = secc[k][{c[1:0], 1'b0}];
        d2_n[k] = secc[k][{c[1:0], 1'b1}];
      end
    end
    d0_n = {(c != 5'd0) || (pkt_idx != 5'd0), hbit, i_vSync, i_hSync};
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hdr_cur <= '0;
      sub_cur <= '0;
      hecc    <= '0;
      secc    <= '0;
    end else begin
      if (load) begin
        hdr_cur <= null_pkt ? 24'h000000 : hdr_mem[rd_ptr];
        sub_cur <= null_pkt ? 224'd0 : sub_mem[rd_ptr];
      end
      if ((state == S_PACKET) && (c < 5'd24)) hecc <= hecc_n;
      if ((state == S_PACKET) && (c < 5'd28)) secc <= secc_n;
    end
  end

  // Every output leaves through a register; flags and nibbles share the same one-cycle lag.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_d0       <= '0;
      o_d1       <= '0;
      o_d2       <= '0;
      o_data     <= 1'b0;
      o_preamble <= 1'b0;
      o_guard    <= 1'b0;
    end else begin
      o_data     <= (state == S_PACKET);
      o_preamble <= (state == S_PREAMBLE);
      o_guard    <= (state == S_LGUARD) || (state == S_TGUARD);
      if (state == S_PACKET) begin
        o_d0 <= d0_n;
        o_d1 <= d1_n;
        o_d2 <= d2_n;
      end else begin
        o_d0 <= {2'b00, i_vSync, i_hSync};
        o_d1 <= '0;
        o_d2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_engine.sv
// Directed bench for hdmi_packet_engine: captures whole islands at the falling clock edge and checks them.
module tb_hdmi_packet_engine;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         h_sync, v_sync, blank, pkt_valid;
  logic         pkt_ready;
  logic [23:0]  pkt_hdr;
  logic [223:0] pkt_sub;
  logic [3:0]   fifo_level;
  logic [3:0]   d0, d1, d2;
  logic         data, preamble, guard, overrun;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [3:0] cap_d0 [128];
  logic [3:0] cap_d1 [128];
  logic [3:0] cap_d2 [128];
  int pre_len, lg_len, data_len, tg_len;
  bit seen;

  logic [55:0]  acr_sub;
  logic [31:0]  w32;
  logic [63:0]  w64;

  hdmi_packet_engine #(.DEPTH(8), .MAX_PKTS(2), .ISLAND_OFFSET(4), .PREAMBLE_LEN(8)) dut (
    .i_pixclk(clk), .i_rst_n(rst_n), .i_hSync(h_sync), .i_vSync(v_sync), .i_blank(blank),
    .i_pkt_valid(pkt_valid), .o_pkt_ready(pkt_ready), .i_pkt_hdr(pkt_hdr), .i_pkt_sub(pkt_sub),
    .o_fifo_level(fifo_level), .o_d0(d0), .o_d1(d1), .o_d2(d2), .o_data(data),
    .o_preamble(preamble), .o_guard(guard), .o_overrun(overrun), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_pkt(input logic [23:0] h, input logic [223:0] s);
    @(negedge clk);
    pkt_valid = 1'b1;
    pkt_hdr   = h;
    pkt_sub   = s;
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  // Raise blank, record one island period by period, then drop blank.
  task automatic run_island(input int abort_at);
    int n;
    pre_len = 0; lg_len = 0; data_len = 0; tg_len = 0; seen = 0;
    @(negedge clk);
    blank = 1'b1;
    n = 0;
    while (!preamble && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (preamble) begin
      seen = 1;
      while (preamble && pre_len < 200) begin pre_len++; @(negedge clk); end
      while (guard && lg_len < 200) begin lg_len++; @(negedge clk); end
      while (data && data_len < 128) begin
        cap_d0[data_len] = d0;
        cap_d1[data_len] = d1;
        cap_d2[data_len] = d2;
        data_len++;
        if (data_len == abort_at) blank = 1'b0;
        @(negedge clk);
      end
      while (guard && tg_len < 200) begin tg_len++; @(negedge clk); end
    end
    blank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] col_d0(input int base, input int b);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = cap_d0[base + i][b];
    return w;
  endfunction

  function automatic logic [63:0] col_sub(input int base, input int k);
    logic [63:0] w;
    for (int i = 0; i < 32; i++) begin
      w[2*i]   = cap_d1[base + i][k];
      w[2*i+1] = cap_d2[base + i][k];
    end
    return w;
  endfunction

  function automatic logic [7:0] sub_ecc(input logic [55:0] s);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < 56; i++) e = {1'b0, e[7:1]} ^ ((e[0] ^ s[i]) ? 8'hC1 : 8'h00);
    return e;
  endfunction

  initial begin
    rst_n = 1'b0; h_sync = 1'b0; v_sync = 1'b0; blank = 1'b0;
    pkt_valid = 1'b0; pkt_hdr = '0; pkt_sub = '0;
    // CTS = 25200 (0x6270), N = 6144 (0x1800): SB1..SB3 = CTS, SB4..SB6 = N
    acr_sub = {8'h00, 8'h18, 8'h00, 8'h70, 8'h62, 8'h00, 8'h00};

    repeat (5) @(negedge clk);
    chk("reset_ready", 64'(pkt_ready), 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_nibbles", 64'({d0, d1, d2}), 64'd0);
    chk("reset_flags", 64'({data, preamble, guard, overrun}), 64'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(pkt_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'(pkt_ready), 64'd1);
    chk("level_after_reset", 64'(fifo_level), 64'd0);

    h_sync = 1'b1; v_sync = 1'b1;
    @(negedge clk);
    chk("idle_sync_passthru", 64'({d0, d1, d2}), 64'h300);
    h_sync = 1'b0; v_sync = 1'b0;

    // All-zero packet
    write_pkt(24'h000000, 224'd0);
    chk("zero_level_in", 64'(fifo_level), 64'd1);
    run_island(-1);
    chk("zero_seen", 64'(seen), 64'd1);
    chk("zero_pre_len", 64'(pre_len), 64'd8);
    chk("zero_lguard_len", 64'(lg_len), 64'd2);
    chk("zero_data_len", 64'(data_len), 64'd32);
    chk("zero_tguard_len", 64'(tg_len), 64'd2);
    chk("zero_d0_bit3", 64'(col_d0(0, 3)), 64'hFFFF_FFFE);
    chk("zero_d0_bit2", 64'(col_d0(0, 2)), 64'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("zero_sub%0d", k), col_sub(0, k), 64'd0);
    chk("zero_level_out", 64'(fifo_level), 64'd0);
    chk("zero_overrun", 64'(overrun), 64'd0);

    // ACR packet; header BCH for 24'h000001 works out to 8'h10
    write_pkt(24'h000001, {4{acr_sub}});
    h_sync = 1'b1;
    run_island(-1);
    h_sync = 1'b0;
    chk("acr_data_len", 64'(data_len), 64'd32);
    chk("acr_first_hdr_bit", 64'(cap_d0[0][2]), 64'd1);
    chk("acr_hdr_stream", 64'(col_d0(0, 2)), 64'h1000_0001);
    chk("acr_hsync", 64'(col_d0(0, 0)), 64'hFFFF_FFFF);
    chk("acr_vsync", 64'(col_d0(0, 1)), 64'd0);
    chk("acr_d0_bit3", 64'(col_d0(0, 3)), 64'hFFFF_FFFE);
    for (int k = 0; k < 4; k++)
      chk($sformatf("acr_sub%0d", k), col_sub(0, k), {sub_ecc(acr_sub), acr_sub});

    // Five packets over three lines: 2, 2, 1
    for (int i = 1; i <= 5; i++) write_pkt(24'h3C5A00 + 24'(i), {4{56'(i) << 8}});
    chk("five_level", 64'(fifo_level), 64'd5);
    for (int isl = 0; isl < 3; isl++) begin
      run_island(-1);
      chk($sformatf("five_isl%0d_len", isl), 64'(data_len), (isl == 2) ? 64'd32 : 64'd64);
      w32 = col_d0(0, 2);
      chk($sformatf("five_isl%0d_hdr0", isl), 64'(w32[23:0]), 64'(24'h3C5A00 + 24'(2*isl + 1)));
      chk($sformatf("five_isl%0d_first_c0", isl), 64'(cap_d0[0][3]), 64'd0);
      if (data_len == 64) begin
        w32 = col_d0(32, 2);
        chk($sformatf("five_isl%0d_hdr1", isl), 64'(w32[23:0]), 64'(24'h3C5A00 + 24'(2*isl + 2)));
        chk($sformatf("five_isl%0d_second_c0", isl), 64'(cap_d0[32][3]), 64'd1);
        w64 = col_sub(32, 0);
        chk($sformatf("five_isl%0d_sub1", isl), 64'(w64[55:0]), 64'(56'(2*isl + 2) << 8));
      end
    end
    chk("five_level_out", 64'(fifo_level), 64'd0);

    // Fill the FIFO; a write while full must be dropped
    for (int i = 0; i < 8; i++) write_pkt(24'h000100 + 24'(i), 224'd0);
    chk("full_level", 64'(fifo_level), 64'd8);
    chk("full_ready", 64'(pkt_ready), 64'd0);
    write_pkt(24'hBADBAD, 224'd0);
    chk("full_level_after_9th", 64'(fifo_level), 64'd8);
    chk("full_ready_after_9th", 64'(pkt_ready), 64'd0);
    for (int isl = 0; isl < 3; isl++) begin
      run_island(-1);
      chk($sformatf("drain%0d_len", isl), 64'(data_len), 64'd64);
    end
    chk("drain_level", 64'(fifo_level), 64'd2);
    chk("drain_ready", 64'(pkt_ready), 64'd1);

    // Blank drops at c=10 of packet 1 of 2
    run_island(11);
    chk("abort_data_len", 64'(data_len), 64'd32);
    chk("abort_tguard_len", 64'(tg_len), 64'd2);
    w32 = col_d0(0, 2);
    chk("abort_hdr", 64'(w32[23:0]), 64'h000106);
    chk("abort_overrun", 64'(overrun), 64'd1);
    chk("abort_level", 64'(fifo_level), 64'd1);

    run_island(-1);
    chk("leftover_len", 64'(data_len), 64'd32);
    w32 = col_d0(0, 2);
    chk("leftover_hdr", 64'(w32[23:0]), 64'h000107);
    chk("leftover_c0", 64'(cap_d0[0][3]), 64'd0);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("leftover_level", 64'(fifo_level), 64'd0);

    // Empty FIFO at the decision point
    run_island(-1);
`ifdef HDMI_PKT_NULL_FILL_EN
    chk("null_seen", 64'(seen), 64'd1);
    chk("null_len", 64'(data_len), 64'd32);
    chk("null_d0_bit3", 64'(col_d0(0, 3)), 64'hFFFF_FFFE);
    chk("null_d0_bit2", 64'(col_d0(0, 2)), 64'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("null_sub%0d", k), col_sub(0, k), 64'd0);
`else
    chk("empty_no_island", 64'(seen), 64'd0);
    chk("empty_no_data", 64'(data_len), 64'd0);
`endif
    chk("empty_level", 64'(fifo_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
